// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int XLEN      = 32;
  localparam int ILEN      = 32;
  localparam int BUF_DEPTH = 2;

  // addi x0, x0, 0 -- what IF/ID carries when it holds a bubble
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    ST_RUN           = 1'b0,
    ST_REDIRECT_WAIT = 1'b1
  } fetch_state_e;

  // One buffered fetch result: the word plus the PC it came from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ibuf_entry_t;

  // Occupancy of a 2-entry FIFO recovered from its full/empty flags
  function automatic logic [1:0] fifo_occ(input logic full, input logic empty);
    return full ? 2'd2 : (empty ? 2'd0 : 2'd1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/grant/response channel.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with synchronous clear; used for granted addresses and fetched words.
module fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [1:0][W-1:0] mem_q;
  logic              rd_q;
  logic              wr_q;
  logic [1:0]        cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  // a push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_push = push_i & ~clr_i & (~full_o | do_pop);

  // storage, pointers and count; clear drops contents but keeps stale data in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (clr_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, talks to imem, buffers words, loads IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCWrite,
  input  logic            IFIDWrite,
  input  logic            IFIDFlush,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] BranchTarget,
  fetch_unit_if.master    imem,
  output logic [ILEN-1:0] IFIDInstr,
  output logic [XLEN-1:0] IFIDPC,
  output logic            IFIDValid
);

  fetch_state_e    state_q;
  logic            req_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] tgt_q;
  logic [1:0]      kill_q;
  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] ifpc_q;
  logic            valid_q;

  logic            granted, pend_nxt, rv_take, rv_live;
  logic            ifid_bubble, ifid_adv, issue;
  logic [XLEN-1:0] af_dout;
  logic            af_full, af_empty;
  ibuf_entry_t     ib_din, ib_dout;
  logic            ib_full, ib_empty, ib_push, ib_pop;
  logic [1:0]      af_occ_nxt, ib_occ_nxt;
  logic [2:0]      occ_nxt;

  assign imem.req  = req_q;
  assign imem.addr = addr_q;
  assign IFIDInstr = instr_q;
  assign IFIDPC    = ifpc_q;
  assign IFIDValid = valid_q;

  assign granted  = req_q & imem.gnt;
  assign pend_nxt = req_q & ~imem.gnt;
  // rvalid with nothing outstanding (orphan after reset) is ignored entirely
  assign rv_take  = imem.rvalid & ~af_empty;
  // killed entries and anything arriving alongside a redirect are wrong-path
  assign rv_live  = rv_take & (kill_q == 2'd0) & ~PCSrc;

  assign ifid_bubble = IFIDFlush | PCSrc;
  assign ifid_adv    = ~ifid_bubble & IFIDWrite;
  assign ib_pop      = ifid_adv & ~ib_empty;
  // bypass straight into IF/ID only when nothing older is waiting
  assign ib_push     = rv_live & ~(ifid_adv & ib_empty);
  assign ib_din      = '{pc: af_dout, instr: imem.rdata};

  // post-cycle occupancy; dead (killed) entries still hold address FIFO slots
  assign af_occ_nxt = fifo_occ(af_full, af_empty) + 2'(granted) - 2'(rv_take);
  assign ib_occ_nxt = PCSrc ? 2'd0 : fifo_occ(ib_full, ib_empty) + 2'(ib_push) - 2'(ib_pop);
  assign occ_nxt    = {1'b0, af_occ_nxt} + {1'b0, ib_occ_nxt};
  assign issue      = PCWrite & (occ_nxt < 3'(BUF_DEPTH));

  fetch_fifo #(.W(XLEN)) u_afifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .push_i  (granted),
    .din_i   (addr_q),
    .pop_i   (rv_take),
    .dout_o  (af_dout),
    .full_o  (af_full),
    .empty_o (af_empty)
  );

  fetch_fifo #(.W($bits(ibuf_entry_t))) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (PCSrc),
    .push_i  (ib_push),
    .din_i   (ib_din),
    .pop_i   (ib_pop),
    .dout_o  (ib_dout),
    .full_o  (ib_full),
    .empty_o (ib_empty)
  );

  // fetch FSM: request issue, PC update, redirect bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
      kill_q  <= 2'd0;
    end else begin
      // an ungranted request stays up at the same address no matter what
      req_q <= pend_nxt | issue;
      if (PCSrc) begin
        // everything granted and still in flight, plus a pending request, is wrong-path
        kill_q <= af_occ_nxt + 2'(pend_nxt);
        if (pend_nxt) begin
          state_q <= ST_REDIRECT_WAIT;
          tgt_q   <= BranchTarget;
        end else begin
          state_q <= ST_RUN;
          addr_q  <= BranchTarget;
        end
      end else begin
        if (rv_take && kill_q != 2'd0) kill_q <= kill_q - 2'd1;
        if (granted) begin
          state_q <= ST_RUN;
          addr_q  <= (state_q == ST_REDIRECT_WAIT) ? tgt_q : addr_q + XLEN'(4);
        end
      end
    end
  end

  // IF/ID register: bubble > hold > oldest buffered word > bypassed response > bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      ifpc_q  <= RESET_PC;
    end else if (ifid_bubble) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
    end else if (IFIDWrite) begin
      if (!ib_empty) begin
        valid_q <= 1'b1;
        instr_q <= ib_dout.instr;
        ifpc_q  <= ib_dout.pc;
      end else if (rv_live) begin
        valid_q <= 1'b1;
        instr_q <= imem.rdata;
        ifpc_q  <= af_dout;
      end else begin
        valid_q <= 1'b0;
        instr_q <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns address-as-data one cycle after grant.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite = 1'b1;
  logic        IFIDWrite = 1'b1;
  logic        IFIDFlush = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic [31:0] IFIDInstr;
  logic [31:0] IFIDPC;
  logic        IFIDValid;

  fetch_unit_if bif();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IFIDFlush    (IFIDFlush),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .imem         (bif),
    .IFIDInstr    (IFIDInstr),
    .IFIDPC       (IFIDPC),
    .IFIDValid    (IFIDValid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          gnt_en = 1'b1;
  bit          rv_en  = 1'b1;
  logic [31:0] mq[$];

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[15];

  // one clock: memory responds/grants on the current outputs, then edge, then sample point
  task automatic step();
    logic        g;
    logic        rv;
    logic [31:0] rd;
    rv = 1'b0;
    rd = '0;
    if (rv_en && mq.size() > 0) begin
      rv = 1'b1;
      rd = mq.pop_front();
    end
    g = bif.req & gnt_en;
    if (g) mq.push_back(bif.addr);
    bif.gnt    = g;
    bif.rvalid = rv;
    bif.rdata  = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic pcw, input logic ifw, input logic fl,
                       input logic ps, input logic [31:0] bt);
    PCWrite      = pcw;
    IFIDWrite    = ifw;
    IFIDFlush    = fl;
    PCSrc        = ps;
    BranchTarget = bt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc);
    logic [31:0] ins;
    ins = valid ? pc : NOP;
    chk({tag, " req"},   32'(bif.req),   32'(req));
    chk({tag, " addr"},  bif.addr,       addr);
    chk({tag, " valid"}, 32'(IFIDValid), 32'(valid));
    chk({tag, " pc"},    IFIDPC,         pc);
    chk({tag, " instr"}, IFIDInstr,      ins);
  endtask

  initial begin
    bif.gnt    = 1'b0;
    bif.rvalid = 1'b0;
    bif.rdata  = '0;

    // expected state after each step, starting at reset release
    tv[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tv[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h10};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h10};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h10};
    tv[10] = '{1'b0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h10};
    tv[11] = '{1'b0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h10};
    tv[12] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    tv[13] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18};
    tv[14] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};

    // reset state
    @(negedge clk);
    step();
    step();
    expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);

    // streaming fetch then a 5-cycle stall, resuming without gap or duplicate
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(tv[i].pcw, tv[i].ifw, 1'b0, 1'b0, 32'h0);
      step();
      expect_out($sformatf("vec%0d", i), tv[i].req, tv[i].addr, tv[i].valid, tv[i].pc);
    end

    // redirect with two responses outstanding: both discarded
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); rv_en = 1'b0;
    step(); expect_out("br_fill",  1'b0, 32'h28,  1'b1, 32'h1C);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    step(); expect_out("br_T",     1'b0, 32'h100, 1'b0, 32'h1C);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); rv_en = 1'b1;
    step(); expect_out("br_kill1", 1'b1, 32'h100, 1'b0, 32'h1C);
    step(); expect_out("br_kill2", 1'b1, 32'h104, 1'b0, 32'h1C);
    step(); expect_out("br_tgt",   1'b1, 32'h108, 1'b1, 32'h100);

    // grant held low 3 cycles with a redirect during the wait
    gnt_en = 1'b0;
    step(); expect_out("gw_0",     1'b1, 32'h108, 1'b1, 32'h104);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    step(); expect_out("gw_br",    1'b1, 32'h108, 1'b0, 32'h104);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(); expect_out("gw_2",     1'b1, 32'h108, 1'b0, 32'h104);
    gnt_en = 1'b1;
    step(); expect_out("gw_gnt",   1'b1, 32'h200, 1'b0, 32'h104);
    step(); expect_out("gw_drop",  1'b1, 32'h204, 1'b0, 32'h104);
    step(); expect_out("gw_tgt",   1'b1, 32'h208, 1'b1, 32'h200);

    // flush wins over hold; the word arriving during the flush is kept
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(); expect_out("fl_T",     1'b0, 32'h20C, 1'b0, 32'h200);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(); expect_out("fl_1",     1'b1, 32'h20C, 1'b1, 32'h204);
    step(); expect_out("fl_2",     1'b1, 32'h210, 1'b1, 32'h208);
    step(); expect_out("fl_3",     1'b1, 32'h214, 1'b1, 32'h20C);

    // async reset with a request outstanding; its late rvalid must be ignored
    rst_n = 1'b0;
    #1;
    expect_out("ar_now", 1'b0, 32'h0, 1'b0, 32'h0);
    rv_en = 1'b0;
    step(); expect_out("ar_hold",  1'b0, 32'h0,   1'b0, 32'h0);
    rst_n = 1'b1;
    rv_en = 1'b1;
    chk("ar_orphan_queued", 32'(mq.size()), 32'd1);
    step(); expect_out("ar_r0",    1'b1, 32'h0,   1'b0, 32'h0);
    step(); expect_out("ar_r1",    1'b1, 32'h4,   1'b0, 32'h0);
    step(); expect_out("ar_r2",    1'b1, 32'h8,   1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
